// File: rtl/track_map_gen.sv
// Obstacle-map column source for the 4-lane runner: one NCOL-column frame per accepted start.
// Optional feature macro SEED_LOAD_EN adds a runtime seed_load/seed port pair.
module track_map_gen #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          NCOL = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef SEED_LOAD_EN
  input  logic        seed_load,
  input  logic [15:0] seed,
`endif
  output logic        busy,
  output logic        in_valid,
  output logic [1:0]  init,
  output logic [1:0]  in0,
  output logic [1:0]  in1,
  output logic [1:0]  in2,
  output logic [1:0]  in3,
  output logic        done
);

  localparam logic [15:0]   SEED_DEF = 16'hACE1;
  localparam logic [15:0]   SEED_RST = (SEED == 16'h0000) ? SEED_DEF : SEED;
  localparam int            CW       = $clog2(NCOL);
  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // An all-road or all-train raw pattern is nudged so every block has 1..3 trains.
  function automatic logic [3:0] train_mask(input logic [15:0] v);
    logic [3:0] one;
    logic [3:0] m;
    one = 4'b0001 << v[5:4];
    case (v[3:0])
      4'h0:    m = one;
      4'hF:    m = ~one;
      default: m = v[3:0];
    endcase
    return m;
  endfunction

  function automatic logic [1:0] rnd3(input logic [1:0] b);
    return (b == 2'd3) ? 2'd0 : b;
  endfunction

  function automatic logic [1:0] first_free(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] sel;
    logic [1:0] lane;
    logic       found;
    sel   = s;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane = s + 2'(i);
      if (!found && !m[lane]) begin
        sel   = lane;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [1:0] lane_val(input logic [2:0] ph, input logic t, input logic [1:0] r);
    logic [1:0] v;
    case (ph)
      3'd0, 3'd1, 3'd3: v = t ? 2'd3 : 2'd0;
      3'd2:             v = t ? 2'd3 : rnd3(r);
      3'd4, 3'd6:       v = rnd3(r);
      default:          v = 2'd0;
    endcase
    return v;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    mask_q, mask_d, mask_now_s, mask_eff_s;
  logic [1:0]    lane0_q, lane0_d;
  logic [15:0]   lfsr_q, lfsr_d, seed_val_s;
  logic          load_s, start_ok_s, block_edge_s;
  logic          busy_q, busy_d, valid_q, valid_d, done_q, done_d;
  logic [1:0]    init_q, init_d;
  logic [7:0]    lanes_q, lanes_d;

`ifdef SEED_LOAD_EN
  assign load_s     = (state_q == IDLE) && seed_load;
  assign seed_val_s = (seed == 16'h0000) ? SEED_DEF : seed;
`else
  assign load_s     = 1'b0;
  assign seed_val_s = SEED_RST;
`endif

  assign start_ok_s   = (state_q == IDLE) && start && !load_s;
  assign mask_now_s   = train_mask(lfsr_q);
  // Blocks after the first take a fresh mask on the very column that opens them.
  assign block_edge_s = (state_q == EMIT) && (col_q[2:0] == 3'd0) && (col_q != {CW{1'b0}});
  assign mask_eff_s   = block_edge_s ? mask_now_s : mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ok_s ? PREP : IDLE;
      PREP:    state_d = EMIT;
      EMIT:    state_d = (col_q == COL_LAST) ? DONE : EMIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    mask_d  = mask_q;
    lane0_d = lane0_q;
    case (state_q)
      PREP: begin
        col_d   = {CW{1'b0}};
        mask_d  = mask_now_s;
        lane0_d = first_free(mask_now_s, lfsr_q[7:6]);
      end
      EMIT: begin
        col_d  = (col_q == COL_LAST) ? {CW{1'b0}} : col_q + CW'(1);
        mask_d = mask_eff_s;
      end
      default: col_d = col_q;
    endcase
    if (state_q != IDLE) lfsr_d = lfsr_step(lfsr_q);
    else if (load_s)     lfsr_d = seed_val_s;
    else                 lfsr_d = lfsr_q;
  end

  always_comb begin
    valid_d = (state_q == EMIT);
    done_d  = (state_q == DONE);
    busy_d  = (state_d != IDLE);
    init_d  = 2'd0;
    lanes_d = 8'd0;
    if (valid_d) begin
      for (int k = 0; k < 4; k++) begin
        lanes_d[2*k +: 2] = lane_val(col_q[2:0], mask_eff_s[k], lfsr_q[2*k +: 2]);
      end
      init_d = (col_q == {CW{1'b0}}) ? lane0_q : 2'd0;
    end else begin
      lanes_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= {CW{1'b0}};
      mask_q  <= 4'd0;
      lane0_q <= 2'd0;
      lfsr_q  <= SEED_RST;
    end else begin
      col_q   <= col_d;
      mask_q  <= mask_d;
      lane0_q <= lane0_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 2'd0;
      lanes_q <= 8'd0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      init_q  <= init_d;
      lanes_q <= lanes_d;
    end
  end

  assign busy     = busy_q;
  assign in_valid = valid_q;
  assign done     = done_q;
  assign init     = init_q;
  assign in0      = lanes_q[1:0];
  assign in1      = lanes_q[3:2];
  assign in2      = lanes_q[5:4];
  assign in3      = lanes_q[7:6];

endmodule
